// File: rtl/updn_cnt_mod.sv
// updn_cnt_mod -- loadable up/down counter with a programmable terminal value.
// The count runs over 0..MAX_VAL and either wraps or saturates at either end
// (selected per cycle by sat). A parallel load, clamped to MAX_VAL, takes
// priority over counting. tc flags an enabled count that is sitting on its
// terminal value in the current direction.
// Optional feature: define UPDN_CNT_STICKY_OVF_EN to add a sticky wrap flag
// (output ovf, cleared by input ovf_clr). Without the macro, neither port
// nor the flag logic exists.
module updn_cnt_mod #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,     // asynchronous, active low
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sat,
`ifdef UPDN_CNT_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] OUT,
  output logic             tc
);

  // All comparisons are made one bit wider than the count so that MAX_VAL+1
  // and 0-1 are representable and never alias onto a legal count value.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   din_ext;
  logic             at_max;
  logic             at_zero;
  logic             din_over;

  // Guard-bit arithmetic and boundary decisions.
  always_comb begin
    cnt_ext  = {1'b0, cnt_q};
    din_ext  = {1'b0, din};
    inc_ext  = cnt_ext + ONE_EXT;
    dec_ext  = cnt_ext - ONE_EXT;
    // ">" rather than "==" keeps the counter recoverable even if it were
    // ever above MAX_VAL; in normal operation this means cnt_q == MAX_VAL.
    at_max   = (inc_ext > MAX_EXT);
    // Borrow out of the guard bit means the count was zero.
    at_zero  = dec_ext[WIDTH];
    din_over = (din_ext > MAX_EXT);
  end

  // Next-count selection: load beats enable, enable beats hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = din_over ? MAX_VAL : din;
    end else if (en) begin
      if (up) begin
        if (at_max) cnt_d = sat ? MAX_VAL : '0;
        else        cnt_d = inc_ext[WIDTH-1:0];
      end else begin
        if (at_zero) cnt_d = sat ? '0 : MAX_VAL;
        else         cnt_d = dec_ext[WIDTH-1:0];
      end
    end
  end

  // Count register; reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Terminal-count flag; forced low while reset is held.
  always_comb begin
    tc = rst & en & ~load & ((up & at_max) | (~up & at_zero));
  end

  assign OUT = cnt_q;

`ifdef UPDN_CNT_STICKY_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky wrap flag: a real wrap (tc without saturation) sets it and wins
  // over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (tc && !sat)   ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: doc/updn_cnt_mod.md
UPDN_CNT_MOD -- requirements
Module: updn_cnt_mod

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value; count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
REQ-003 Port clk, input, 1 bit, single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-low reset: 0 resets the counter, 1 lets it run.
REQ-005 Port en, input, 1 bit, count enable.
REQ-006 Port up, input, 1 bit, direction: 1 counts up, 0 counts down.
REQ-007 Port load, input, 1 bit, synchronous parallel load strobe.
REQ-008 Port din, input, WIDTH bits, parallel load value.
REQ-009 Port sat, input, 1 bit, boundary mode: 1 saturates, 0 wraps.
REQ-010 Port OUT, output, WIDTH bits, registered count value.
REQ-011 Port tc, output, 1 bit, combinational terminal-count flag.

Function
REQ-012 Priority at each rising clk edge SHALL be: load, then en, then hold.
REQ-013 load=1 SHALL set OUT to din on that edge, or to MAX_VAL if din > MAX_VAL; en, up and sat are ignored.
REQ-014 load=0 with en=0 SHALL hold OUT unchanged.
REQ-015 en=1, up=1, OUT < MAX_VAL SHALL set OUT to OUT+1.
REQ-016 en=1, up=1, OUT == MAX_VAL SHALL set OUT to 0 when sat=0, and hold MAX_VAL when sat=1.
REQ-017 en=1, up=0, OUT > 0 SHALL set OUT to OUT-1.
REQ-018 en=1, up=0, OUT == 0 SHALL set OUT to MAX_VAL when sat=0, and hold 0 when sat=1.
REQ-019 Count latency SHALL be one clock: inputs sampled at edge N are reflected on OUT after edge N.
REQ-020 tc SHALL be 1 iff en=1, load=0, and either (up=1 and OUT==MAX_VAL) or (up=0 and OUT==0), regardless of sat.
REQ-021 Changes on up or sat SHALL take effect at the next edge, with no pipeline state.
REQ-022 OUT SHALL never hold a value above MAX_VAL, under any input sequence.
REQ-023 Arithmetic SHALL be done at WIDTH bits plus one guard bit; no intermediate truncation may corrupt the wrap or saturate decision.

Reset
REQ-024 rst=0 SHALL force OUT=0 immediately, without waiting for clk, and clear all internal state (ovf included when compiled in).
REQ-025 While rst=0, all inputs SHALL be ignored and tc SHALL read 0.
REQ-026 The first state change after rst rises SHALL occur at the first following rising clk edge.
REQ-027 Asserting rst during a count or load SHALL abandon that operation; OUT reads 0.

Configuration
REQ-028 Macro UPDN_CNT_STICKY_OVF_EN, when defined, SHALL add input ovf_clr (1 bit) and output ovf (1 bit, registered).
REQ-029 With the macro defined:
  - ovf SHALL set to 1 on any edge where tc=1 and sat=0, that is, an actual wrap.
  - ovf SHALL stay 1 until ovf_clr=1 is sampled.
  - If set and clear occur on the same edge, set SHALL win.
REQ-030 With the macro undefined, ports ovf and ovf_clr SHALL be absent and no flag logic synthesised; all other behaviour is identical.

Verification (WIDTH=4, MAX_VAL=9)
REQ-031 Scenario 1: rst=0 then 1; en=1, up=1, sat=0 for 12 clocks -> OUT 1..9, 0, 1, 2; tc=1 exactly while OUT=9.
REQ-032 Scenario 2: load din=7, then up=0, sat=1 for 10 clocks -> OUT 7, 6..0, then holds at 0; tc=1 while OUT=0.
REQ-033 Scenario 3: load din=15 -> OUT=9. Then load=1 and en=1 with din=3 on the same edge -> OUT=3; load wins.
REQ-034 Scenario 4: OUT=5, en=1; drop rst to 0 between clock edges -> OUT=0 before the next edge and stays 0 while rst=0.
REQ-035 Scenario 5: OUT=9, up=1, sat=1, then sat changes to 0 -> OUT holds 9 for one clock, then 0 on the first edge with sat=0.
REQ-036 Scenario 6 (macro defined): wrap from 9 to 0 -> ovf=1. ovf_clr=1 with no wrap -> ovf=0. ovf_clr=1 on a wrap edge -> ovf stays 1.
